// File: rtl/swap_bank_ctrl.sv
// swap_bank_ctrl: DEPTH x WIDTH register bank with LOAD / SWAP / ROTATE commands
// over a valid/ready handshake. Swaps and rotations update every affected entry
// on a single edge, so no temporary register is needed.
// Optional feature: define ROT_ABORT_EN to add rot_abort / aborted.
module swap_bank_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_idx_a,
    input  logic [AW-1:0]    cmd_idx_b,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [AW-1:0]    cmd_count,
`ifdef ROT_ABORT_EN
    input  logic             rot_abort,
    output logic             aborted,
`endif
    input  logic [AW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_SWAP = 2'b10;
    localparam logic [1:0] OP_ROT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROT  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [DEPTH-1:0][WIDTH-1:0]  r_bank;
    logic [AW-1:0]                r_cnt;
    logic                         w_accept;
    logic                         w_abort;
    logic                         w_shift;

`ifdef ROT_ABORT_EN
    logic                         r_aborted;

    // Abort only has meaning while a rotation is in progress
    assign w_abort = rot_abort & (r_state == ST_ROT);

    // Aborted pulses in the DONE cycle that follows an abort edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_aborted <= 1'b0;
        else     r_aborted <= w_abort;
    end

    assign aborted = r_aborted;
`else
    assign w_abort = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode and status outputs
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_shift   = 1'b0;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                w_accept  = cmd_valid;
                if (cmd_valid) begin
                    if (cmd_op == OP_ROT && cmd_count != '0) w_next = ST_ROT;
                    else                                      w_next = ST_DONE;
                end
            end
            ST_ROT: begin
                if (w_abort) begin
                    w_next = ST_DONE;
                end else begin
                    w_shift = 1'b1;
                    if (r_cnt == AW'(1)) w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Rotation step counter, latched at accept and decremented per shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                r_cnt <= '0;
        else if (w_accept && cmd_op == OP_ROT)  r_cnt <= cmd_count;
        else if (w_shift)                       r_cnt <= r_cnt - AW'(1);
    end

    // Bank update: load, same-edge swap, or one-step rotate toward higher index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank <= '0;
        end else if (w_accept) begin
            case (cmd_op)
                OP_LOAD: r_bank[cmd_idx_a] <= cmd_data;
                OP_SWAP: begin
                    r_bank[cmd_idx_a] <= r_bank[cmd_idx_b];
                    r_bank[cmd_idx_b] <= r_bank[cmd_idx_a];
                end
                OP_NOP, OP_ROT: ;
                default: ;
            endcase
        end else if (w_shift) begin
            r_bank <= {r_bank[DEPTH-2:0], r_bank[DEPTH-1]};
        end
    end

    assign rd_data = r_bank[rd_idx];

endmodule
